// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencing controller for the 5-stage RV32I core.
// Drives stage-register enables/flushes for load-use bubbles, taken-branch
// flushes and data-memory wait freezes; latches a sticky timeout fault and
// keeps a saturating count of frozen-PC cycles.
module pipeline_hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned STALL_CNT_W = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rstn,
  input  logic [4:0]             i_ID_rnum1,
  input  logic [4:0]             i_ID_rnum2,
  input  logic                   i_ID_use1,
  input  logic                   i_ID_use2,
  input  logic [4:0]             i_EX_wnum,
  input  logic                   i_EX_memRead,
  input  logic                   i_EX_branchTaken,
  input  logic                   i_MEM_memReq,
  input  logic                   i_dmem_ack,
  output logic                   o_dmem_req,
  output logic                   o_pc_en,
  output logic                   o_IFID_en,
  output logic                   o_IDEX_en,
  output logic                   o_EXMEM_en,
  output logic                   o_MEMWB_en,
  output logic                   o_IFID_flush,
  output logic                   o_IDEX_flush,
  output logic                   o_MEMWB_bubble,
  output logic                   o_timeout_err,
  output logic [STALL_CNT_W-1:0] o_stall_cycles
);

  localparam int unsigned WCW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(MEM_TIMEOUT - 1);

  typedef enum logic [1:0] {RUN, MEM_WAIT, FAULT} state_t;

  state_t                 state_q, state_d;
  logic [WCW-1:0]         wait_cnt_q, wait_cnt_d;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic                   load_use;
  logic                   mem_stall;

  assign load_use = i_EX_memRead && (i_EX_wnum != '0) &&
                    ((i_ID_use1 && (i_ID_rnum1 == i_EX_wnum)) ||
                     (i_ID_use2 && (i_ID_rnum2 == i_EX_wnum)));

  // Hazard resolution: memory freeze > branch flush > load-use bubble.
  // While in reset the whole pipeline is enabled and loaded with NOPs.
  always_comb begin
    o_dmem_req     = 1'b0;
    mem_stall      = 1'b0;
    o_pc_en        = 1'b1;
    o_IFID_en      = 1'b1;
    o_IDEX_en      = 1'b1;
    o_EXMEM_en     = 1'b1;
    o_MEMWB_en     = 1'b1;
    o_IFID_flush   = 1'b0;
    o_IDEX_flush   = 1'b0;
    o_MEMWB_bubble = 1'b0;
    if (!i_rstn) begin
      o_IFID_flush   = 1'b1;
      o_IDEX_flush   = 1'b1;
      o_MEMWB_bubble = 1'b1;
    end else if (state_q == FAULT) begin
      o_pc_en    = 1'b0;
      o_IFID_en  = 1'b0;
      o_IDEX_en  = 1'b0;
      o_EXMEM_en = 1'b0;
      o_MEMWB_en = 1'b0;
    end else begin
      o_dmem_req = (state_q == RUN) ? i_MEM_memReq : 1'b1;
      mem_stall  = o_dmem_req && !i_dmem_ack;
      if (mem_stall) begin
        o_pc_en        = 1'b0;
        o_IFID_en      = 1'b0;
        o_IDEX_en      = 1'b0;
        o_EXMEM_en     = 1'b0;
        o_MEMWB_bubble = 1'b1;
      end else if (i_EX_branchTaken) begin
        o_IFID_flush = 1'b1;
        o_IDEX_flush = 1'b1;
      end else if (load_use) begin
        o_pc_en      = 1'b0;
        o_IFID_en    = 1'b0;
        o_IDEX_flush = 1'b1;
      end
    end
  end

  // Next state, memory wait counter and saturating stall counter.
  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    stall_cnt_d = stall_cnt_q;
    case (state_q)
      RUN: begin
        if (mem_stall) begin
          state_d    = MEM_WAIT;
          wait_cnt_d = '0;
        end
      end
      MEM_WAIT: begin
        if (i_dmem_ack) begin
          state_d = RUN;
        end else if (wait_cnt_q == WAIT_LAST) begin
          state_d = FAULT;
        end else begin
          wait_cnt_d = wait_cnt_q + WCW'(1);
        end
      end
      FAULT:   state_d = FAULT;
      default: state_d = RUN;
    endcase
    if (!o_pc_en && (state_q != FAULT) && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state_q     <= RUN;
      wait_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Status outputs read as cleared for the whole reset interval.
  assign o_timeout_err  = i_rstn && (state_q == FAULT);
  assign o_stall_cycles = i_rstn ? stall_cnt_q : '0;

endmodule
